// File: rtl/sar_control_nonbinary_mc.sv
`default_nettype none
// ============================================================================
//  Module      : sar_control_nonbinary_mc
//  Description : Redundant-weight SAR ADC controller with majority-vote
//                averaging, multi-channel scan and valid/ready result port.
//  Revision    : 1.0
// ============================================================================
module sar_control_nonbinary_mc #(
    parameter int RES_BITS      = 10,
    parameter int NUM_STEPS     = 12,
    parameter logic [NUM_STEPS*RES_BITS-1:0] WEIGHTS = {
        10'd201, 10'd121, 10'd74, 10'd45, 10'd27, 10'd17,
        10'd10,  10'd6,   10'd4,  10'd2,  10'd1,  10'd1},
    parameter int AVG_STEPS     = 3,
    parameter int SAMPLE_CYCLES = 2,
    parameter int NUM_CHANNELS  = 4,
    parameter int CH_W          = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_in,
    input  logic                continuous_in,
    input  logic [CH_W-1:0]     channel_in,
    input  logic [2:0]          avg_sel_in,
    input  logic                comparator_in,
    output logic                sample_out,
    output logic                sample_out_n,
    output logic                busy_out,
    output logic [CH_W-1:0]     channel_out,
    output logic [RES_BITS-1:0] pswitch_out,
    output logic [RES_BITS-1:0] nswitch_out,
    output logic [RES_BITS-1:0] result_out,
    output logic [CH_W-1:0]     result_ch_out,
    output logic                result_valid_out,
    input  logic                result_ready_in,
    output logic                overrun_out
);

    localparam int c_CW        = RES_BITS + 2;
    localparam int c_STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam int c_SCNT_W    = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam int c_FIRST_AVG = NUM_STEPS - AVG_STEPS;
    localparam logic signed [c_CW-1:0] c_MID = c_CW'(2 ** (RES_BITS - 1));
    localparam logic signed [c_CW-1:0] c_MAX = c_CW'(2 ** RES_BITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                    state_q;
    logic signed [c_CW-1:0]    code_q;
    logic signed [c_CW-1:0]    code_d;
    logic [c_STEP_W-1:0]       step_q;
    logic [c_SCNT_W-1:0]       scnt_q;
    logic [4:0]                avg_cnt_q;
    logic [4:0]                sum_q;
    logic [4:0]                n_q;
    logic                      cont_q;
    logic                      last_dec_q;
    logic                      sample_q;
    logic                      busy_q;
    logic [CH_W-1:0]           channel_q;
    logic [RES_BITS-1:0]       result_q;
    logic [CH_W-1:0]           result_ch_q;
    logic                      valid_q;
    logic                      overrun_q;

    logic [RES_BITS-1:0]       w_weights [NUM_STEPS];
    logic [RES_BITS-1:0]       w_weight;
    logic                      w_is_avg;
    logic                      w_step_last;
    logic [5:0]                w_ones;
    logic                      w_decision;
    logic [4:0]                w_n_start;
    logic signed [c_CW-1:0]    w_corrected;
    logic [RES_BITS-1:0]       w_clamped;
    logic [CH_W-1:0]           w_next_ch;

    // Step 0 lives in the most significant slice of the weight table.
    for (genvar k = 0; k < NUM_STEPS; k++) begin : g_weights
        assign w_weights[k] = WEIGHTS[(NUM_STEPS-1-k)*RES_BITS +: RES_BITS];
    end

    always_comb begin
        w_weight    = w_weights[step_q];
        w_is_avg    = (32'(step_q) >= 32'(c_FIRST_AVG));
        w_step_last = !w_is_avg || (avg_cnt_q == (n_q - 5'd1));
        w_ones      = {1'b0, sum_q} + {5'd0, comparator_in};
        w_decision  = w_is_avg ? (w_ones >= (({1'b0, n_q} + 6'd1) >> 1))
                               : comparator_in;
        code_d      = w_decision ? (code_q + $signed({2'b00, w_weight}))
                                 : (code_q - $signed({2'b00, w_weight}));
        w_corrected = last_dec_q ? code_q : (code_q - c_CW'(1));
        if (w_corrected[c_CW-1]) begin
            w_clamped = '0;
        end else if (w_corrected > c_MAX) begin
            w_clamped = '1;
        end else begin
            w_clamped = w_corrected[RES_BITS-1:0];
        end
        w_next_ch = (channel_q == CH_W'(NUM_CHANNELS - 1)) ? '0 : (channel_q + CH_W'(1));
        case (avg_sel_in)
            3'd0:    w_n_start = 5'd1;
            3'd1:    w_n_start = 5'd3;
            3'd2:    w_n_start = 5'd7;
            3'd3:    w_n_start = 5'd15;
            default: w_n_start = 5'd31;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            code_q      <= c_MID;
            step_q      <= '0;
            scnt_q      <= '0;
            avg_cnt_q   <= '0;
            sum_q       <= '0;
            n_q         <= 5'd1;
            cont_q      <= 1'b0;
            last_dec_q  <= 1'b0;
            sample_q    <= 1'b0;
            busy_q      <= 1'b0;
            channel_q   <= '0;
            result_q    <= '0;
            result_ch_q <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (valid_q && result_ready_in) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        state_q   <= SAMPLE;
                        channel_q <= channel_in;
                        cont_q    <= continuous_in;
                        n_q       <= w_n_start;
                        sample_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        scnt_q    <= '0;
                    end
                end
                SAMPLE: begin
                    if (scnt_q == c_SCNT_W'(SAMPLE_CYCLES - 1)) begin
                        state_q   <= CONVERT;
                        sample_q  <= 1'b0;
                        step_q    <= '0;
                        avg_cnt_q <= '0;
                        sum_q     <= '0;
                    end else begin
                        scnt_q <= scnt_q + c_SCNT_W'(1);
                    end
                end
                CONVERT: begin
                    // Averaged steps accumulate votes until the N-th cycle decides.
                    if (!w_step_last) begin
                        avg_cnt_q <= avg_cnt_q + 5'd1;
                        sum_q     <= w_ones[4:0];
                    end else begin
                        code_q     <= code_d;
                        last_dec_q <= w_decision;
                        avg_cnt_q  <= '0;
                        sum_q      <= '0;
                        if (step_q == c_STEP_W'(NUM_STEPS - 1)) begin
                            state_q <= DONE;
                        end else begin
                            step_q <= step_q + c_STEP_W'(1);
                        end
                    end
                end
                DONE: begin
                    result_q    <= w_clamped;
                    result_ch_q <= channel_q;
                    valid_q     <= 1'b1;
                    code_q      <= c_MID;
                    if (valid_q && !result_ready_in) begin
                        overrun_q <= 1'b1;
                    end
                    if (cont_q && continuous_in) begin
                        state_q   <= SAMPLE;
                        sample_q  <= 1'b1;
                        scnt_q    <= '0;
                        channel_q <= w_next_ch;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample_out       = sample_q;
    assign sample_out_n     = ~sample_q;
    assign busy_out         = busy_q;
    assign channel_out      = channel_q;
    assign nswitch_out      = code_q[RES_BITS-1:0];
    assign pswitch_out      = ~code_q[RES_BITS-1:0];
    assign result_out       = result_q;
    assign result_ch_out    = result_ch_q;
    assign result_valid_out = valid_q;
    assign overrun_out      = overrun_q;

endmodule
`default_nettype wire

// File: doc/sar_control_nonbinary_mc.md
Name: sar_control_nonbinary_mc

Overview:
Parametrised next-generation non-binary (redundant) SAR ADC controller. It handles any resolution and step count through a per-step weight table. It adds start/busy control, single-shot and continuous-scan modes, and multi-channel input selection. Results are delivered through a valid/ready output handshake with overrun detection and saturating correction. It sits between the capacitor-DAC switch matrix and comparator on one side and the digital result consumer on the other.

Parameters:
RES_BITS, 10, result and DAC code width.
NUM_STEPS, 12, number of redundant decision steps.
WEIGHTS, {201,121,74,45,27,17,10,6,4,2,1,1}, packed NUM_STEPS*RES_BITS; step 0 in the most significant slice.
AVG_STEPS, 3, number of final steps that use averaging.
SAMPLE_CYCLES, 2, length of the sampling phase in cycles (>=1).
NUM_CHANNELS, 4, number of analog channels (>=1).
CH_W, 2, channel index width, equal to clog2(NUM_CHANNELS) with a minimum of 1.

Ports:
clk  in  1  sole clock.
rst  in  1  synchronous, active-high reset.
start_in  in  1  conversion request; sampled only in IDLE.
continuous_in  in  1  1 = free-running scan; sampled at start.
channel_in  in  CH_W  first channel; sampled at start.
avg_sel_in  in  3  averaging select, sampled at start: 0→N=1, 1→3, 2→7, 3→15, 4+→31.
comparator_in  in  1  comparator decision, 1 = input above DAC.
sample_out  out  1  sampling switch on.
sample_out_n  out  1  inverse of sample_out.
busy_out  out  1  high in any state other than IDLE.
channel_out  out  CH_W  analog mux select.
pswitch_out  out  RES_BITS  ~code.
nswitch_out  out  RES_BITS  code.
result_out  out  RES_BITS  corrected result.
result_ch_out  out  CH_W  channel tag of result_out.
result_valid_out  out  1  result available.
result_ready_in  in  1  consumer accepts the result.
overrun_out  out  1  sticky: an unconsumed result was overwritten.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, code=2^(RES_BITS-1), sample_out=0, sample_out_n=1, busy_out=0, channel_out=0, result_out=0, result_ch_out=0, result_valid_out=0, overrun_out=0, all counters=0. Reset takes priority over every other event, including mid-conversion; no result is produced for an aborted conversion.
- State machine IDLE→SAMPLE→CONVERT→DONE→(IDLE, or SAMPLE when continuous).
- IDLE: on start_in=1, latch channel_in, continuous_in and avg_sel_in, then go to SAMPLE.
- SAMPLE: sample_out=1 for exactly SAMPLE_CYCLES cycles; code held at 2^(RES_BITS-1).
- CONVERT, step k (0..NUM_STEPS-1):
  - Non-averaged steps (k < NUM_STEPS-AVG_STEPS) take 1 cycle. comparator_in is sampled at the cycle's end; code ← code+W[k] if 1, else code−W[k].
  - Averaged steps take N cycles. Count the ones in sum[4:0]; decision = (sum >= (N+1)/2), which is a majority vote. Then update code once.
- Internal code arithmetic uses RES_BITS+2 bits, signed, with no wrap.
- DONE (1 cycle): corrected = code if the last decision was 1, else code−1. Clamp corrected to [0, 2^RES_BITS−1]. Load result_out and result_ch_out, set result_valid_out=1, then reset code to mid-scale.
- Output handshake: a transfer occurs when valid and ready are both high at an edge; valid then drops the next cycle unless DONE loads a new result in that same cycle.
- If DONE loads while valid=1 and ready=0: overwrite the result and set overrun_out=1. overrun_out clears only on rst.
- Continuous mode: after DONE, channel_out ← (channel_out+1) wrapping at NUM_CHANNELS−1→0, then go to SAMPLE. Deasserting continuous_in takes effect at the next DONE, which then returns to IDLE.
- Single mode: DONE→IDLE; channel_out holds its value.
- start_in is ignored while busy.
- Latency: with start accepted at edge t, result_valid_out is first high in cycle t+SAMPLE_CYCLES+NUM_STEPS+AVG_STEPS*(N−1)+1. With defaults and N=1 this is t+15.

Test Plan:
- Defaults, N=1, comparator_in held 1, start on channel 2 → result 1021 (512+509, last decision 1), result_ch=2, valid exactly 15 cycles after start.
- comparator_in held 0 → code 3, last decision 0 → result 2; pswitch/nswitch complementary on every cycle.
- avg_sel=1 (N=3), comparator pattern 1,0,1 repeating in the averaged steps → each averaged decision is 1, and the conversion takes 6 extra cycles.
- Continuous mode, NUM_CHANNELS=4, start at channel 3, result_ready_in=1 → result_ch sequence 3,0,1,2; clearing continuous_in stops the scan after the current DONE.
- result_ready_in=0 across two results → second result visible, overrun_out=1 and staying 1; rst pulse mid-CONVERT → IDLE next cycle, every output at its reset value, no valid pulse.
- Override WEIGHTS step 0 = 700 with comparator_in held 1 → result clamps to 1023 with no wrap.
